// File: rtl/multi_cycle_controller_if.sv
// Control bus between the multi-cycle controller and its datapath.
// The master (controller) reads IR opcode, ALU zero and the memory handshake, and drives every enable/select.
interface multi_cycle_controller_if;
    logic       en;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemToReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic       ExtOp;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       instr_done;
    logic       fault;
    logic [1:0] fault_code;
    logic [3:0] state;

    modport master (
        input  en, op, zero, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
               RegWrite, ALUSrcA, ExtOp, ALUSrcB, ALUOp, PCSource, instr_done, fault,
               fault_code, state
    );

    modport slave (
        output en, op, zero, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
               RegWrite, ALUSrcA, ExtOp, ALUSrcB, ALUOp, PCSource, instr_done, fault,
               fault_code, state
    );
endinterface

// File: rtl/multi_cycle_controller.sv
// Moore sequencer for a shared-ALU/shared-memory multi-cycle datapath (R/ori/lw/sw/beq/j).
// Control word is registered from the next state; only the memory-completion terms follow mem_ready directly.
module multi_cycle_controller #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic                            clk,
    input  logic                            rst_n,
    multi_cycle_controller_if.master        bus
);
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        EXEC_R   = 4'd7,
        R_WB     = 4'd8,
        EXEC_I   = 4'd9,
        I_WB     = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12,
        FAULT    = 4'd15
    } fsmState;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic       extOp;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic [1:0] pcSource;
        logic       done;
        logic       fetchPhase;
        logic       writePhase;
    } ctrlWord;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] CODE_ILLEGAL = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;
    localparam logic [7:0] WAIT_LAST    = 8'(WAIT_LIMIT - 1);

    fsmState    stateReg;
    fsmState    stateNext;
    fsmState    afterDone;
    logic [7:0] waitReg;
    logic [7:0] waitNext;
    logic [1:0] faultCodeReg;
    logic [1:0] faultCodeNext;
    logic       faultReg;
    logic       memStall;
    ctrlWord    ctrlReg;
    logic       unusedZero;

    // The ALU zero flag is consumed by the datapath together with PCWriteCond.
    assign unusedZero = bus.zero;

    function automatic ctrlWord controlsFor(fsmState s);
        ctrlWord c;
        c = '0;
        case (s)
            FETCH: begin
                c.memRead    = 1'b1;
                c.aluSrcB    = 2'b01;
                c.fetchPhase = 1'b1;
            end
            DECODE: begin
                c.aluSrcB = 2'b11;
                c.extOp   = 1'b1;
            end
            MEM_ADDR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
                c.extOp   = 1'b1;
            end
            MEM_RD: begin
                c.memRead = 1'b1;
                c.iorD    = 1'b1;
            end
            MEM_WB: begin
                c.regWrite = 1'b1;
                c.memToReg = 1'b1;
                c.done     = 1'b1;
            end
            MEM_WR: begin
                c.memWrite   = 1'b1;
                c.iorD       = 1'b1;
                c.writePhase = 1'b1;
            end
            EXEC_R: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = 3'b001;
            end
            R_WB: begin
                c.regWrite = 1'b1;
                c.regDst   = 1'b1;
                c.done     = 1'b1;
            end
            EXEC_I: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
                c.aluOp   = 3'b010;
            end
            I_WB: begin
                c.regWrite = 1'b1;
                c.done     = 1'b1;
            end
            BRANCH: begin
                c.aluSrcA     = 1'b1;
                c.aluOp       = 3'b100;
                c.pcWriteCond = 1'b1;
                c.pcSource    = 2'b01;
                c.done        = 1'b1;
            end
            JUMP: begin
                c.pcWrite  = 1'b1;
                c.pcSource = 2'b10;
                c.done     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign afterDone = bus.en ? FETCH : IDLE;

    always_comb begin
        stateNext     = stateReg;
        faultCodeNext = faultCodeReg;
        waitNext      = 8'd0;
        memStall      = 1'b0;
        case (stateReg)
            IDLE:     if (bus.en) stateNext = FETCH;
            FETCH:    if (bus.mem_ready) stateNext = DECODE; else memStall = 1'b1;
            DECODE: begin
                case (bus.op)
                    OP_RTYPE:      stateNext = EXEC_R;
                    OP_ORI:        stateNext = EXEC_I;
                    OP_LW, OP_SW:  stateNext = MEM_ADDR;
                    OP_BEQ:        stateNext = BRANCH;
                    OP_J:          stateNext = JUMP;
                    default: begin
                        stateNext     = FAULT;
                        faultCodeNext = CODE_ILLEGAL;
                    end
                endcase
            end
            MEM_ADDR: begin
                // The IR still holds the opcode, so lw/sw is re-read here rather than stored.
                if (bus.op == OP_LW) begin
                    stateNext = MEM_RD;
                end else if (bus.op == OP_SW) begin
                    stateNext = MEM_WR;
                end else begin
                    stateNext     = FAULT;
                    faultCodeNext = CODE_ILLEGAL;
                end
            end
            MEM_RD:   if (bus.mem_ready) stateNext = MEM_WB; else memStall = 1'b1;
            MEM_WR:   if (bus.mem_ready) stateNext = afterDone; else memStall = 1'b1;
            EXEC_R:   stateNext = R_WB;
            EXEC_I:   stateNext = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP: stateNext = afterDone;
            FAULT:    stateNext = FAULT;
            default:  stateNext = IDLE;
        endcase

        // A stalled access either counts one more wait cycle or gives up on the last tolerated one.
        if (memStall) begin
            if (waitReg == WAIT_LAST) begin
                stateNext     = FAULT;
                faultCodeNext = CODE_TIMEOUT;
            end else begin
                waitNext = waitReg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg     <= IDLE;
            waitReg      <= 8'd0;
            faultCodeReg <= 2'b00;
            faultReg     <= 1'b0;
            ctrlReg      <= '0;
        end else begin
            stateReg     <= stateNext;
            waitReg      <= waitNext;
            faultCodeReg <= faultCodeNext;
            faultReg     <= (stateNext == FAULT);
            ctrlReg      <= controlsFor(stateNext);
        end
    end

    // Instruction fetch and store completion must track mem_ready within the same cycle.
    assign bus.IRWrite     = ctrlReg.fetchPhase & bus.mem_ready;
    assign bus.PCWrite     = ctrlReg.pcWrite | (ctrlReg.fetchPhase & bus.mem_ready);
    assign bus.instr_done  = ctrlReg.done | (ctrlReg.writePhase & bus.mem_ready);
    assign bus.PCWriteCond = ctrlReg.pcWriteCond;
    assign bus.IorD        = ctrlReg.iorD;
    assign bus.MemRead     = ctrlReg.memRead;
    assign bus.MemWrite    = ctrlReg.memWrite;
    assign bus.MemToReg    = ctrlReg.memToReg;
    assign bus.RegDst      = ctrlReg.regDst;
    assign bus.RegWrite    = ctrlReg.regWrite;
    assign bus.ALUSrcA     = ctrlReg.aluSrcA;
    assign bus.ExtOp       = ctrlReg.extOp;
    assign bus.ALUSrcB     = ctrlReg.aluSrcB;
    assign bus.ALUOp       = ctrlReg.aluOp;
    assign bus.PCSource    = ctrlReg.pcSource;
    assign bus.fault       = faultReg;
    assign bus.fault_code  = faultCodeReg;
    assign bus.state       = stateReg;
endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: directed scenarios, then random traffic, all checked every cycle
// against a route-per-instruction model of the control sequence.
module tb_multi_cycle_controller;
    localparam int WAIT_LIMIT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    multi_cycle_controller_if bus ();

    multi_cycle_controller #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [25:0] dutOut;
    assign dutOut = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                     bus.MemToReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ExtOp, bus.ALUSrcB,
                     bus.ALUOp, bus.PCSource, bus.instr_done, bus.fault, bus.fault_code, bus.state};

    // Model: the list of states an instruction walks through, plus the stall count of the current access.
    int         expState = 0;
    logic [1:0] expCode = 2'b00;
    int         waitCnt = 0;
    int         route[$];
    int         pos = 0;

    function automatic logic [25:0] modelVec(int st, logic [1:0] code, logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ext, done, flt;
        logic [1:0] asb, psrc;
        logic [2:0] aop;
        pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0; rdst = 0; rw = 0;
        asa = 0; ext = 0; done = 0; flt = 0; asb = 2'b00; psrc = 2'b00; aop = 3'b000;
        case (st)
            1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            2:  begin asb = 2'b11; ext = 1; end
            3:  begin asa = 1; asb = 2'b10; ext = 1; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; done = 1; end
            6:  begin mwr = 1; iord = 1; done = mr; end
            7:  begin asa = 1; aop = 3'b001; end
            8:  begin rw = 1; rdst = 1; done = 1; end
            9:  begin asa = 1; asb = 2'b10; aop = 3'b010; end
            10: begin rw = 1; done = 1; end
            11: begin asa = 1; aop = 3'b100; pcwc = 1; psrc = 2'b01; done = 1; end
            12: begin pcw = 1; psrc = 2'b10; done = 1; end
            15: flt = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ext, asb, aop, psrc, done, flt,
                code, 4'(st)};
    endfunction

    task automatic modelReset();
        expState = 0;
        expCode  = 2'b00;
        waitCnt  = 0;
        pos      = 0;
        route.delete();
    endtask

    task automatic startInstr();
        route    = '{1, 2};
        pos      = 0;
        expState = 1;
    endtask

    task automatic modelAdvance();
        if (expState == 0) begin
            if (bus.en) startInstr();
        end else if (expState != 15) begin
            if ((expState == 1 || expState == 4 || expState == 6) && !bus.mem_ready) begin
                if (waitCnt == WAIT_LIMIT - 1) begin
                    expState = 15;
                    expCode  = 2'b10;
                    waitCnt  = 0;
                end else begin
                    waitCnt++;
                end
            end else begin
                waitCnt = 0;
                if (expState == 2) begin
                    case (bus.op)
                        6'b000000: begin route.push_back(7); route.push_back(8); end
                        6'b001101: begin route.push_back(9); route.push_back(10); end
                        6'b100011: begin route.push_back(3); route.push_back(4); route.push_back(5); end
                        6'b101011: begin route.push_back(3); route.push_back(6); end
                        6'b000100: route.push_back(11);
                        6'b000010: route.push_back(12);
                        default: begin
                            expState = 15;
                            expCode  = 2'b01;
                        end
                    endcase
                end
                if (expState != 15) begin
                    pos++;
                    if (pos < route.size()) expState = route[pos];
                    else if (bus.en) startInstr();
                    else expState = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) modelAdvance();
        #1;
    endtask

    task automatic checkLit(string name, int actual, int want);
        total++;
        if (actual != want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, want, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [25:0] want;
        want = rst_n ? modelVec(expState, expCode, bus.mem_ready) : 26'd0;
        total++;
        if (dutOut !== want) begin
            bad++;
            $display("FAIL cycle-outputs: got %h, expected %h (model state %0d, t=%0t)",
                     dutOut, want, expState, $time);
        end
    end

    function automatic logic [5:0] pickOp();
        logic [5:0] ops [6];
        ops = '{6'b000000, 6'b001101, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
        if ($urandom_range(0, 24) == 0) return 6'($urandom);
        return ops[$urandom_range(0, 5)];
    endfunction

    initial begin
        bus.en = 1'b0; bus.op = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        step();
        checkLit("reset-state", int'(bus.state), 0);
        checkLit("reset-outputs", int'(dutOut), 0);

        // R-type, no wait states
        rst_n = 1'b1; bus.en = 1'b1; bus.op = 6'b000000; bus.mem_ready = 1'b1;
        step(); checkLit("r-fetch", int'(bus.state), 1); checkLit("r-irwrite", int'(bus.IRWrite), 1);
        step(); checkLit("r-decode", int'(bus.state), 2);
        step(); checkLit("r-exec", int'(bus.state), 7);
        step(); checkLit("r-wb", int'(bus.state), 8);
        checkLit("r-regwrite", int'(bus.RegWrite), 1);
        checkLit("r-regdst", int'(bus.RegDst), 1);
        checkLit("r-done", int'(bus.instr_done), 1);
        checkLit("model-r-wb", expState, 8);
        $display("txn R-type done at t=%0t", $time);

        // lw with two stalled read cycles
        bus.op = 6'b100011;
        step(); checkLit("lw-fetch", int'(bus.state), 1);
        step(); checkLit("lw-decode", int'(bus.state), 2);
        step(); checkLit("lw-addr", int'(bus.state), 3);
        step(); checkLit("lw-rd", int'(bus.state), 4); checkLit("lw-rd-memtoreg", int'(bus.MemToReg), 0);
        bus.mem_ready = 1'b0;
        step(); checkLit("lw-rd-wait1", int'(bus.state), 4);
        step(); checkLit("lw-rd-wait2", int'(bus.state), 4);
        bus.mem_ready = 1'b1;
        step(); checkLit("lw-wb", int'(bus.state), 5);
        checkLit("lw-wb-memtoreg", int'(bus.MemToReg), 1);
        checkLit("lw-wb-done", int'(bus.instr_done), 1);
        $display("txn lw (2 waits) done at t=%0t", $time);

        // beq
        bus.op = 6'b000100;
        step(); step();
        step(); checkLit("beq-state", int'(bus.state), 11);
        checkLit("beq-pcwritecond", int'(bus.PCWriteCond), 1);
        checkLit("beq-aluop", int'(bus.ALUOp), 4);
        checkLit("beq-pcsource", int'(bus.PCSource), 1);
        step(); checkLit("beq-next-fetch", int'(bus.state), 1);
        $display("txn beq done at t=%0t", $time);

        // illegal opcode
        bus.op = 6'b111111;
        step(); checkLit("ill-decode", int'(bus.state), 2);
        step(); checkLit("ill-state", int'(bus.state), 15);
        checkLit("ill-fault", int'(bus.fault), 1);
        checkLit("ill-code", int'(bus.fault_code), 1);
        checkLit("model-ill-code", int'(expCode), 1);
        bus.en = 1'b0; step(); bus.en = 1'b1; step();
        checkLit("ill-sticky", int'(bus.state), 15);
        rst_n = 1'b0; modelReset(); #1;
        checkLit("ill-reset-state", int'(bus.state), 0);
        checkLit("ill-reset-fault", int'(bus.fault), 0);
        step();
        $display("txn illegal op faulted at t=%0t", $time);

        // fetch timeout
        rst_n = 1'b1; bus.en = 1'b1; bus.mem_ready = 1'b0;
        step();
        for (int i = 1; i <= 15; i++) begin
            checkLit("to-fetch", int'(bus.state), 1);
            checkLit("to-irwrite", int'(bus.IRWrite), 0);
            step();
        end
        checkLit("to-state", int'(bus.state), 15);
        checkLit("to-code", int'(bus.fault_code), 2);
        $display("txn fetch timeout faulted at t=%0t", $time);

        // sw interrupted by async reset, then sw with en dropped
        rst_n = 1'b0; modelReset(); step();
        rst_n = 1'b1; bus.en = 1'b1; bus.op = 6'b101011; bus.mem_ready = 1'b1;
        step(); step(); step();
        step(); checkLit("sw-memwr", int'(bus.state), 6);
        bus.mem_ready = 1'b0;
        #2 rst_n = 1'b0; modelReset(); #1;
        checkLit("sw-async-outputs", int'(dutOut), 0);
        step();
        rst_n = 1'b1; bus.mem_ready = 1'b1;
        step(); step(); step();
        step(); checkLit("sw2-memwr", int'(bus.state), 6);
        bus.en = 1'b0; #1;
        checkLit("sw2-done", int'(bus.instr_done), 1);
        step(); checkLit("sw2-idle", int'(bus.state), 0);
        step(); checkLit("sw2-idle-hold", int'(bus.state), 0);
        $display("txn sw with reset and en drop done at t=%0t", $time);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            bus.en = ($urandom_range(0, 9) != 0);
            bus.mem_ready = ((c % 600) >= 570) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (expState == 0 || expState == 1) bus.op = pickOp();
            if (expState == 15) begin
                rst_n = 1'b0;
                modelReset();
                $display("txn random: fault cleared by reset at t=%0t", $time);
            end else begin
                rst_n = 1'b1;
                if ($urandom_range(0, 199) == 0) begin
                    #2 rst_n = 1'b0;
                    modelReset();
                end
            end
            if (expState == 1 && pos == 0 && waitCnt == 0 && bus.mem_ready)
                $display("txn random: fetch op=%b t=%0t", bus.op, $time);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
